filter_bias_buffer_param: RTL

- Parametrised, clocked successor of the 5x5 filter/bias store in the CNN datapath.
- Holds FILTER_DEPTH KxK kernels and BIAS_DEPTH biases for the convolution engine.
- Kernels load row-serially through a valid/ready handshake into a shadow register and commit atomically. Biases stream in one per beat.
- The read port serves one full kernel plus one bias per request, with fixed 1-cycle latency, concurrently with loading.

---
 rtl/filter_bias_buffer_param.sv | 195 +++++++++++++++++++
 1 files changed

// File: rtl/filter_bias_buffer_param.sv
`default_nettype none
// ==========================================================================
// filter_bias_buffer_param : KxK kernel / bias store with handshake loading
// Revision 1.0 - initial release
// ==========================================================================
module filter_bias_buffer_param #(
  parameter int DATA_W       = 16,
  parameter int K            = 5,
  parameter int FILTER_DEPTH = 1920,
  parameter int BIAS_DEPTH   = 120,
  parameter int FI_W         = $clog2(FILTER_DEPTH),
  parameter int BI_W         = $clog2(BIAS_DEPTH + 1)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  ld_start,
  input  logic                  ld_mode,
  input  logic [FI_W-1:0]       ld_index,
  input  logic [BI_W-1:0]       ld_len,
  input  logic                  wr_valid,
  output logic                  wr_ready,
  input  logic [K*DATA_W-1:0]   wr_data,
  output logic                  busy,
  output logic                  finish,
  output logic                  ld_err,
  input  logic                  rd_en,
  input  logic [FI_W-1:0]       rd_filter_idx,
  input  logic [BI_W-1:0]       rd_bias_idx,
  output logic                  rd_valid,
  output logic [K*K*DATA_W-1:0] rd_filter,
  output logic [DATA_W-1:0]     rd_bias
);

  localparam int ROW_W = K * DATA_W;
  localparam int KER_W = K * ROW_W;
  localparam int RC_W  = (K > 1) ? $clog2(K) : 1;
  localparam int SUM_W = ((FI_W > BI_W) ? FI_W : BI_W) + 1;
  localparam logic [FI_W:0]     C_FDEPTH   = (FI_W + 1)'(FILTER_DEPTH);
  localparam logic [BI_W:0]     C_BDEPTH   = (BI_W + 1)'(BIAS_DEPTH);
  localparam logic [SUM_W-1:0]  C_BEND     = SUM_W'(BIAS_DEPTH);
  localparam logic [RC_W-1:0]   C_LAST_ROW = RC_W'(K - 1);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    LOAD_K = 2'd1,
    LOAD_B = 2'd2
  } state_t;

  state_t                  state_q, state_d;
  logic [FI_W-1:0]         kidx_q, kidx_d;
  logic [BI_W-1:0]         base_q, base_d;
  logic [BI_W-1:0]         len_q, len_d;
  logic [BI_W-1:0]         bcnt_q, bcnt_d;
  logic [RC_W-1:0]         row_q, row_d;
  logic                    finish_q, finish_d;
  logic                    ld_err_q, ld_err_d;
  logic                    rd_valid_q, rd_valid_d;
  logic [KER_W-1:0]        rd_filter_q, rd_filter_d;
  logic [DATA_W-1:0]       rd_bias_q, rd_bias_d;
  logic [K-1:0][ROW_W-1:0] shadow_q, shadow_d;

  logic [KER_W-1:0]  kbuf_mem [FILTER_DEPTH];
  logic [DATA_W-1:0] bias_mem [BIAS_DEPTH];

  logic             beat;
  logic             k_we;
  logic             b_we;
  logic [BI_W-1:0]  b_waddr;
  logic [SUM_W-1:0] b_end;
  logic             k_ok;
  logic             b_ok;

  assign wr_ready = (state_q != IDLE);
  assign busy     = wr_ready;
  assign finish   = finish_q;
  assign ld_err   = ld_err_q;
  assign rd_valid = rd_valid_q;
  assign rd_filter = rd_filter_q;
  assign rd_bias  = rd_bias_q;

  always_comb begin
    beat    = wr_valid && wr_ready;
    b_end   = SUM_W'(ld_index) + SUM_W'(ld_len);
    k_ok    = ({1'b0, ld_index} < C_FDEPTH);
    b_ok    = (ld_len != '0) && ({1'b0, ld_len} <= C_BDEPTH) && (b_end <= C_BEND);
    b_waddr = base_q + bcnt_q;

    state_d  = state_q;
    kidx_d   = kidx_q;
    base_d   = base_q;
    len_d    = len_q;
    bcnt_d   = bcnt_q;
    row_d    = row_q;
    finish_d = 1'b0;
    ld_err_d = 1'b0;
    shadow_d = shadow_q;
    k_we     = 1'b0;
    b_we     = 1'b0;

    case (state_q)
      IDLE: begin
        if (ld_start) begin
          if (ld_mode && k_ok) begin
            kidx_d  = ld_index;
            row_d   = '0;
            state_d = LOAD_K;
          end else if (!ld_mode && b_ok) begin
            base_d  = BI_W'(ld_index);
            len_d   = ld_len;
            bcnt_d  = '0;
            state_d = LOAD_B;
          end else begin
            ld_err_d = 1'b1;
          end
        end
      end
      LOAD_K: begin
        if (beat) begin
          // Commit uses shadow_d so the final row lands in the same write.
          shadow_d[row_q] = wr_data;
          if (row_q == C_LAST_ROW) begin
            k_we     = 1'b1;
            row_d    = '0;
            finish_d = 1'b1;
            state_d  = IDLE;
          end else begin
            row_d = row_q + RC_W'(1);
          end
        end
      end
      LOAD_B: begin
        if (beat) begin
          b_we = 1'b1;
          if (bcnt_q == len_q - BI_W'(1)) begin
            bcnt_d   = '0;
            finish_d = 1'b1;
            state_d  = IDLE;
          end else begin
            bcnt_d = bcnt_q + BI_W'(1);
          end
        end
      end
      default: state_d = IDLE;
    endcase

    rd_valid_d  = rd_en;
    rd_filter_d = rd_filter_q;
    rd_bias_d   = rd_bias_q;
    if (rd_en) begin
      rd_filter_d = ({1'b0, rd_filter_idx} < C_FDEPTH) ? kbuf_mem[rd_filter_idx] : '0;
      rd_bias_d   = ({1'b0, rd_bias_idx} < C_BDEPTH) ? bias_mem[rd_bias_idx] : '0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      kidx_q      <= '0;
      base_q      <= '0;
      len_q       <= '0;
      bcnt_q      <= '0;
      row_q       <= '0;
      finish_q    <= 1'b0;
      ld_err_q    <= 1'b0;
      rd_valid_q  <= 1'b0;
      rd_filter_q <= '0;
      rd_bias_q   <= '0;
    end else begin
      state_q     <= state_d;
      kidx_q      <= kidx_d;
      base_q      <= base_d;
      len_q       <= len_d;
      bcnt_q      <= bcnt_d;
      row_q       <= row_d;
      finish_q    <= finish_d;
      ld_err_q    <= ld_err_d;
      rd_valid_q  <= rd_valid_d;
      rd_filter_q <= rd_filter_d;
      rd_bias_q   <= rd_bias_d;
    end
  end

  // Storage is never cleared; reads in the same cycle see pre-write contents.
  always_ff @(posedge clk) begin
    shadow_q <= shadow_d;
    if (k_we && !rst) begin
      kbuf_mem[kidx_q] <= shadow_d;
    end
    if (b_we && !rst) begin
      bias_mem[b_waddr] <= wr_data[DATA_W-1:0];
    end
  end

endmodule
`default_nettype wire
